// File: rtl/via6522_bus_responder.sv
// via6522_bus_responder: Mac-style 6522 VIA subset behind a 68000 bus.
// It provides a 16-entry register map, ports A/B, timers T1/T2, a byte-wide shift
// register, CA1/CA2 edge flags, and IFR/IER with a registered interrupt output.
// All register side effects happen once per bus cycle, on the edge where the strobe is
// first accepted. The acknowledge is then delayed by c_dtack_cycles clocks.
module via6522_bus_responder #(
    parameter int unsigned c_dtack_cycles = 2,
    parameter logic [7:0]  c_ora_reset    = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic [3:0] rs,
    input  logic       as_n,
    input  logic       uds_n,
    input  logic       rw,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dtack_n,
    output logic       irq_n,
    input  logic       tick_en,
    input  logic       ca1,
    input  logic       ca2,
    input  logic       sr_strobe,
    input  logic [7:0] sr_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } t_bus_state;

    // Last value of the wait counter before the acknowledge is issued.
    localparam logic [2:0] c_wait_last = 3'(c_dtack_cycles - 1);

    t_bus_state r_state;
    t_bus_state w_state_nxt;
    logic [2:0] r_wait_cnt;
    logic [2:0] w_wait_cnt_nxt;
    logic       r_dtack_n;
    logic       w_dtack_n_nxt;
    logic [7:0] r_dout;
    logic       r_irq_n;

    logic [7:0] r_ora;
    logic [7:0] r_orb;
    logic [7:0] r_ddra;
    logic [7:0] r_ddrb;
    logic [7:0] r_acr;
    logic [7:0] r_pcr;
    logic [7:0] r_sr;
    logic [6:0] r_ier;
    logic [6:0] r_ifr;

    logic [15:0] r_t1_cnt;
    logic [15:0] r_t1_latch;
    logic        r_t1_armed;
    logic [15:0] r_t2_cnt;
    logic [7:0]  r_t2_latch_lo;
    logic        r_t2_armed;

    logic [2:0] r_ca1_sync;
    logic [2:0] r_ca2_sync;

    logic        w_strobe;
    logic        w_acc;
    logic        w_wr;
    logic        w_rd;
    logic [15:0] w_sel;
    logic [15:0] w_wr_r;
    logic [15:0] w_rd_r;
    logic [15:0] w_acc_r;
    logic [7:0]  w_rd_data;
    logic [7:0]  w_pa_rd;
    logic [7:0]  w_pb_rd;
    logic        w_ifr7;
    logic        w_t1_fire;
    logic        w_t2_fire;
    logic        w_ca1_edge;
    logic        w_ca2_edge;
    logic        w_ca1_rise;
    logic        w_ca2_rise;
    logic [6:0]  w_ifr_set;
    logic [6:0]  w_ifr_clr;

    // A register access is accepted only in IDLE, so it is taken exactly once per strobe.
    assign w_strobe = cs & ~as_n & ~uds_n;
    assign w_acc    = (r_state == S_IDLE) & w_strobe;
    assign w_wr     = w_acc & ~rw;
    assign w_rd     = w_acc & rw;
    assign w_sel    = 16'h0001 << rs;
    assign w_wr_r   = w_sel & {16{w_wr}};
    assign w_rd_r   = w_sel & {16{w_rd}};
    assign w_acc_r  = w_wr_r | w_rd_r;

    // Bus FSM: state, wait counter and registered dtack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
            r_dtack_n  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_dtack_n  <= w_dtack_n_nxt;
        end
    end

    // Bus FSM next state. Releasing as_n ends the cycle from both WAIT and ACK.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_dtack_n_nxt  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 3'd0;
                end
            end
            S_WAIT: begin
                if (as_n) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_state_nxt   = S_ACK;
                    w_dtack_n_nxt = 1'b0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            S_ACK: begin
                if (as_n) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dtack_n_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Port read-back: output bits return the output register, input bits return the pin.
    assign w_pa_rd = (pa_in & ~r_ddra) | (r_ora & r_ddra);
    assign w_pb_rd = (pb_in & ~r_ddrb) | (r_orb & r_ddrb);
    assign w_ifr7  = |(r_ifr & r_ier);

    // Read-data multiplexer. It is sampled before same-edge read-clear side effects apply.
    always_comb begin
        w_rd_data = 8'h00;
        case (rs)
            4'h0: w_rd_data = w_pb_rd;
            4'h1: w_rd_data = w_pa_rd;
            4'h2: w_rd_data = r_ddrb;
            4'h3: w_rd_data = r_ddra;
            4'h4: w_rd_data = r_t1_cnt[7:0];
            4'h5: w_rd_data = r_t1_cnt[15:8];
            4'h6: w_rd_data = r_t1_latch[7:0];
            4'h7: w_rd_data = r_t1_latch[15:8];
            4'h8: w_rd_data = r_t2_cnt[7:0];
            4'h9: w_rd_data = r_t2_cnt[15:8];
            4'hA: w_rd_data = r_sr;
            4'hB: w_rd_data = r_acr;
            4'hC: w_rd_data = r_pcr;
            4'hD: w_rd_data = {w_ifr7, r_ifr};
            4'hE: w_rd_data = {1'b1, r_ier};
            4'hF: w_rd_data = w_pa_rd;
            default: w_rd_data = 8'h00;
        endcase
    end

    // Capture read data when a read is accepted, and hold it through the acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= 8'h00;
        end else if (w_rd) begin
            r_dout <= w_rd_data;
        end
    end

    // Plain read/write registers: ports, DDRs, ACR, PCR and IER.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ora  <= c_ora_reset;
            r_orb  <= 8'h00;
            r_ddra <= 8'h00;
            r_ddrb <= 8'h00;
            r_acr  <= 8'h00;
            r_pcr  <= 8'h00;
            r_ier  <= 7'h00;
        end else begin
            if (w_wr_r[0]) r_orb <= din;
            if (w_wr_r[1] | w_wr_r[15]) r_ora <= din;
            if (w_wr_r[2]) r_ddrb <= din;
            if (w_wr_r[3]) r_ddra <= din;
            if (w_wr_r[11]) r_acr <= din;
            if (w_wr_r[12]) r_pcr <= din;
            if (w_wr_r[14]) begin
                if (din[7]) r_ier <= r_ier | din[6:0];
                else        r_ier <= r_ier & ~din[6:0];
            end
        end
    end

    // Shift register. A completed keyboard byte takes priority over a CPU write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr <= 8'h00;
        end else if (sr_strobe) begin
            r_sr <= sr_in;
        end else if (w_wr_r[10]) begin
            r_sr <= din;
        end
    end

    // Timer 1: one-shot or free-running. A high-byte counter write wins over a same-clock tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t1_cnt   <= 16'h0000;
            r_t1_latch <= 16'h0000;
            r_t1_armed <= 1'b0;
        end else begin
            if (w_wr_r[4] | w_wr_r[6]) r_t1_latch[7:0] <= din;
            if (w_wr_r[5] | w_wr_r[7]) r_t1_latch[15:8] <= din;
            if (w_wr_r[5]) begin
                r_t1_cnt   <= {din, r_t1_latch[7:0]};
                r_t1_armed <= 1'b1;
            end else if (tick_en) begin
                if (r_t1_cnt == 16'h0000) begin
                    if (r_acr[6]) begin
                        r_t1_cnt <= r_t1_latch;
                    end else begin
                        r_t1_cnt   <= 16'hFFFF;
                        r_t1_armed <= 1'b0;
                    end
                end else begin
                    r_t1_cnt <= r_t1_cnt - 16'd1;
                end
            end
        end
    end

    // Timer 2: one-shot down counter that keeps wrapping after it has fired.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t2_cnt      <= 16'h0000;
            r_t2_latch_lo <= 8'h00;
            r_t2_armed    <= 1'b0;
        end else begin
            if (w_wr_r[8]) r_t2_latch_lo <= din;
            if (w_wr_r[9]) begin
                r_t2_cnt   <= {din, r_t2_latch_lo};
                r_t2_armed <= 1'b1;
            end else if (tick_en) begin
                r_t2_cnt <= r_t2_cnt - 16'd1;
                if (r_t2_cnt == 16'h0000) r_t2_armed <= 1'b0;
            end
        end
    end

    assign w_t1_fire = tick_en & ~w_wr_r[5] & r_t1_armed & (r_t1_cnt == 16'h0000);
    assign w_t2_fire = tick_en & ~w_wr_r[9] & r_t2_armed & (r_t2_cnt == 16'h0000);

    // Two-flop synchronisers for CA1/CA2, plus a third stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ca1_sync <= 3'b000;
            r_ca2_sync <= 3'b000;
        end else begin
            r_ca1_sync <= {r_ca1_sync[1:0], ca1};
            r_ca2_sync <= {r_ca2_sync[1:0], ca2};
        end
    end

    assign w_ca1_rise = r_ca1_sync[1] & ~r_ca1_sync[2];
    assign w_ca2_rise = r_ca2_sync[1] & ~r_ca2_sync[2];
    assign w_ca1_edge = r_pcr[0] ? w_ca1_rise : (~r_ca1_sync[1] & r_ca1_sync[2]);
    assign w_ca2_edge = r_pcr[2] ? w_ca2_rise : (~r_ca2_sync[1] & r_ca2_sync[2]);

    // Flag events and their clear sources. Bits 4:3 have no source and only clear.
    assign w_ifr_set = {w_t1_fire, w_t2_fire, 2'b00, sr_strobe, w_ca1_edge, w_ca2_edge};
    always_comb begin
        w_ifr_clr = w_wr_r[13] ? din[6:0] : 7'h00;
        if (w_rd_r[4] | w_wr_r[5] | w_wr_r[7]) w_ifr_clr[6] = 1'b1;
        if (w_rd_r[8] | w_wr_r[9]) w_ifr_clr[5] = 1'b1;
        if (w_acc_r[10]) w_ifr_clr[2] = 1'b1;
        if (w_acc_r[1]) w_ifr_clr[1:0] = 2'b11;
    end

    // Interrupt flags. A set event in the same clock as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifr <= 7'h00;
        end else begin
            r_ifr <= (r_ifr & ~w_ifr_clr) | w_ifr_set;
        end
    end

    // Registered interrupt request. It lags the flag state by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_n <= 1'b1;
        end else begin
            r_irq_n <= ~w_ifr7;
        end
    end

    assign dout    = r_dout;
    assign dtack_n = r_dtack_n;
    assign irq_n   = r_irq_n;
    assign pa_out  = r_ora;
    assign pb_out  = r_orb;
    assign pa_oe   = r_ddra;
    assign pb_oe   = r_ddrb;

endmodule

// File: tb/tb_via6522_bus_responder.sv
// Testbench for via6522_bus_responder. It runs bus cycles and checks reads against a
// scoreboard of expected bytes that is filled when each read is issued.
module tb_via6522_bus_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0;
    logic [3:0] rs = 4'h0;
    logic       as_n = 1'b1;
    logic       uds_n = 1'b1;
    logic       rw = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dtack_n;
    logic       irq_n;
    logic       tick_en = 1'b0;
    logic       ca1 = 1'b0;
    logic       ca2 = 1'b0;
    logic       sr_strobe = 1'b0;
    logic [7:0] sr_in = 8'h00;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [7:0] pa_oe;
    logic [7:0] pb_oe;
    logic [7:0] pa_in = 8'h3C;
    logic [7:0] pb_in = 8'hC3;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];
    string      sb_tag[$];

    via6522_bus_responder #(.c_dtack_cycles(2), .c_ora_reset(8'h10)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .rs(rs), .as_n(as_n), .uds_n(uds_n),
        .rw(rw), .din(din), .dout(dout), .dtack_n(dtack_n), .irq_n(irq_n),
        .tick_en(tick_en), .ca1(ca1), .ca2(ca2), .sr_strobe(sr_strobe), .sr_in(sr_in),
        .pa_out(pa_out), .pb_out(pb_out), .pa_oe(pa_oe), .pb_oe(pb_oe),
        .pa_in(pa_in), .pb_in(pb_in)
    );

    always #5 clk = ~clk;

    // Watchdog timer that stops the run if the bench stalls.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One bus cycle. sr_mode: 0 none, 1 sr_strobe on the accept edge, 2 sr_strobe during ACK.
    task automatic bus(input logic r, input logic [3:0] a, input logic [7:0] d,
                       input int hold, input int sr_mode);
        int lat;
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; uds_n = 1'b0; rw = r; rs = a; din = d;
        if (sr_mode == 1) sr_strobe = 1'b1;
        lat = 0;
        while (lat < 16) begin
            @(negedge clk);
            sr_strobe = 1'b0;
            lat++;
            if (dtack_n == 1'b0) break;
        end
        chk("dtack_lat", lat, 3);
        if (r && sb_q.size() != 0) chk(sb_tag.pop_front(), dout, sb_q.pop_front());
        if (sr_mode == 2) begin
            sr_strobe = 1'b1;
            @(negedge clk);
            sr_strobe = 1'b0;
        end
        repeat (hold) @(negedge clk);
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; rw = 1'b1;
        @(negedge clk);
        chk("dtack_rel", dtack_n, 1);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus(1'b0, a, d, 0, 0);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        sb_q.push_back(exp);
        sb_tag.push_back(tag);
        bus(1'b1, a, 8'h00, 0, 0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick_en = 1'b1;
            @(negedge clk); tick_en = 1'b0;
        end
    endtask

    task automatic pulse_sr(input logic [7:0] v);
        @(negedge clk); sr_in = v; sr_strobe = 1'b1;
        @(negedge clk); sr_strobe = 1'b0;
    endtask

    initial begin
        int low_seen;
        int waitc;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dtack", dtack_n, 1);
        chk("rst_irq", irq_n, 1);
        chk("rst_pa_out", pa_out, 8'h10);
        chk("rst_pa_oe", pa_oe, 8'h00);
        chk("rst_pb_out", pb_out, 8'h00);
        reset_n = 1'b1;
        rd("rd_porta_in", 4'hF, 8'h3C);

        // Port configuration and read-back.
        wr(4'h3, 8'hFF);
        wr(4'hF, 8'h00);
        chk("pa_out", pa_out, 8'h00);
        chk("pa_oe", pa_oe, 8'hFF);
        rd("rd_ora", 4'h1, 8'h00);
        rd("rd_ddra", 4'h3, 8'hFF);
        wr(4'h2, 8'h0F);
        wr(4'h0, 8'hA5);
        chk("pb_out", pb_out, 8'hA5);
        rd("rd_orb_mix", 4'h0, 8'hC5);

        // T1 one-shot mode.
        wr(4'h6, 8'h03);
        wr(4'h7, 8'h00);
        wr(4'hE, 8'hC0);
        rd("rd_ier", 4'hE, 8'hC0);
        wr(4'h5, 8'h00);
        tick(3);
        rd("t1_ifr_early", 4'hD, 8'h00);
        chk("t1_irq_early", irq_n, 1);
        tick(1);
        repeat (2) @(negedge clk);
        chk("t1_irq_set", irq_n, 0);
        rd("t1_ifr_set", 4'hD, 8'hC0);
        rd("t1_cnt_lo_ffff", 4'h4, 8'hFF);
        chk("t1_irq_clr", irq_n, 1);
        tick(2);
        rd("t1_cnt_lo_fd", 4'h4, 8'hFD);
        rd("t1_no_refire", 4'hD, 8'h00);

        // T1 free-running mode.
        wr(4'hB, 8'h40);
        wr(4'h6, 8'h02);
        wr(4'h7, 8'h00);
        wr(4'h5, 8'h00);
        for (int p = 0; p < 2; p++) begin
            tick(2);
            rd("fr_ifr_quiet", 4'hD, 8'h00);
            tick(1);
            rd("fr_ifr_set", 4'hD, 8'hC0);
            wr(4'hD, 8'h40);
            rd("fr_ifr_clr", 4'hD, 8'h00);
        end
        rd("fr_reload", 4'h4, 8'h02);
        wr(4'hE, 8'h7F);
        wr(4'hD, 8'h7F);

        // CA1 rising-edge flag.
        wr(4'hC, 8'h01);
        wr(4'hE, 8'h82);
        ca1 = 1'b1;
        repeat (4) @(negedge clk);
        rd("ca1_ifr", 4'hD, 8'h82);
        chk("ca1_irq", irq_n, 0);
        rd("ca1_rdF", 4'hF, 8'h00);
        rd("ca1_keep", 4'hD, 8'h82);
        rd("ca1_rd1", 4'h1, 8'h00);
        rd("ca1_cleared", 4'hD, 8'h00);
        chk("ca1_irq_clr", irq_n, 1);
        ca1 = 1'b0;
        repeat (4) @(negedge clk);
        rd("ca1_fall_ign", 4'hD, 8'h00);

        // Shift register and set-over-clear collision.
        pulse_sr(8'hA5);
        rd("sr_ifr", 4'hD, 8'h04);
        rd("sr_data", 4'hA, 8'hA5);
        rd("sr_ifr_clr", 4'hD, 8'h00);
        sr_in = 8'h5A;
        bus(1'b0, 4'hD, 8'h04, 0, 1);
        rd("sr_set_wins", 4'hD, 8'h04);
        rd("sr_data2", 4'hA, 8'h5A);
        rd("sr_ifr_clr2", 4'hD, 8'h00);

        // A long acknowledge clears IFR only once.
        pulse_sr(8'h33);
        bus(1'b0, 4'hD, 8'h04, 20, 2);
        rd("hold_once", 4'hD, 8'h04);
        rd("hold_sr", 4'hA, 8'h33);

        // Abort during WAIT commits the write but never asserts dtack.
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; uds_n = 1'b0; rw = 1'b0; rs = 4'hF; din = 8'h55;
        @(negedge clk);
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1; rw = 1'b1;
        low_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (dtack_n == 1'b0) low_seen++;
        end
        chk("abort_dtack", low_seen, 0);
        chk("abort_pa", pa_out, 8'h55);
        rd("abort_rd", 4'hF, 8'h55);

        // T2 countdown.
        wr(4'h8, 8'h05);
        wr(4'h9, 8'h00);
        tick(3);
        rd("t2_lo", 4'h8, 8'h02);
        rd("t2_hi", 4'h9, 8'h00);

        // Asynchronous reset while in ACK.
        @(negedge clk);
        cs = 1'b1; as_n = 1'b0; uds_n = 1'b0; rw = 1'b1; rs = 4'hF;
        waitc = 0;
        while (waitc < 16 && dtack_n == 1'b1) begin
            @(negedge clk);
            waitc++;
        end
        chk("rst_in_ack", dtack_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_dtack", dtack_n, 1);
        chk("rst_async_dout", dout, 8'h00);
        @(negedge clk);
        cs = 1'b0; as_n = 1'b1; uds_n = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst2_pa_out", pa_out, 8'h10);
        chk("rst2_pa_oe", pa_oe, 8'h00);
        chk("rst2_irq", irq_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
